// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared FP32 types and constants for the matrix compute path
package matrix_pkg;

    localparam int FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

endpackage : matrix_pkg

// File: rtl/fp32_addsub.sv
// rtl/fp32_addsub.sv - combinational truncating FP32 add/sub with a trailing result register
module fp32_addsub
    import matrix_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  fp32_t a,
    input  fp32_t b,
    input  logic  sub,
    output fp32_t y,
    output logic  overflow,
    output fp32_t y_q
);

    logic        sa;
    logic        sb;
    logic        a_big;
    logic        x_s;
    logic        y_s;
    logic [7:0]  x_e;
    logic [7:0]  y_e;
    logic [22:0] x_m;
    logic [22:0] y_m;
    logic [7:0]  x_ee;
    logic [7:0]  y_ee;
    logic [7:0]  d;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] my_al;
    logic [27:0] s;
    logic [26:0] norm;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [22:0] m;

    // Align, add/subtract magnitudes, normalise and truncate; zero results are +0
    always_comb begin
        sa       = a[31];
        sb       = b[31] ^ sub;
        a_big    = (a[30:0] >= b[30:0]);
        x_s      = a_big ? sa : sb;
        y_s      = a_big ? sb : sa;
        x_e      = a_big ? a[30:23] : b[30:23];
        y_e      = a_big ? b[30:23] : a[30:23];
        x_m      = a_big ? a[22:0] : b[22:0];
        y_m      = a_big ? b[22:0] : a[22:0];
        x_ee     = (x_e == 8'd0) ? 8'd1 : x_e;
        y_ee     = (y_e == 8'd0) ? 8'd1 : y_e;
        mx       = {(x_e != 8'd0), x_m, 3'b000};
        my       = {(y_e != 8'd0), y_m, 3'b000};
        d        = x_ee - y_ee;
        my_al    = (d >= 8'd27) ? 27'd0 : (my >> d);
        s        = (x_s == y_s) ? ({1'b0, mx} + {1'b0, my_al})
                                : ({1'b0, mx} - {1'b0, my_al});
        lz       = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        norm     = s[26:0] << lz;
        e        = 10'd0;
        m        = 23'd0;
        y        = FP32_POS_ZERO;
        overflow = 1'b0;
        if (s != 28'd0) begin
            if (s[27]) begin
                e = 10'(x_ee) + 10'd1;
                m = 23'(s >> 4);
            end else begin
                e = 10'(x_ee) - 10'(lz);
                m = 23'(norm >> 3);
            end
            if (e[9] || (e == 10'd0)) begin
                y = {x_s, 31'd0};
            end else if (e >= 10'(FP32_EXP_MAX)) begin
                y        = {x_s, FP32_EXP_MAX, 23'd0};
                overflow = 1'b1;
            end else begin
                y = {x_s, e[7:0], m};
            end
        end
    end

    // Stage register kept for callers that want a registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= FP32_POS_ZERO;
        else     y_q <= y;
    end

endmodule : fp32_addsub

// File: rtl/fp32_addsub_rr_arb.sv
// rtl/fp32_addsub_rr_arb.sv - round-robin sharing of one fp32_addsub among NUM_REQ requesters
module fp32_addsub_rr_arb
    import matrix_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output fp32_t                 rsp_y,
    output logic                  rsp_overflow,
    output logic [31:0]           ops_cnt
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;
    logic            accept;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    fp32_t           rsp_y_q;
    logic            rsp_overflow_q;
    logic [31:0]     ops_cnt_q;
    fp32_t           add_a;
    fp32_t           add_b;
    logic            add_sub;
    fp32_t           add_y;
    logic            add_ovf;
    fp32_t           unused_stage_y;

    // Round-robin scan from rr_ptr; with no grant the mux index stays at rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[ID_W-1:0];
            end
        end
        req_ready = '0;
        if (gnt_found && !hold && !rst) req_ready[gnt_idx] = 1'b1;
        accept    = |req_ready;
        add_a     = req_a[32*gnt_idx +: 32];
        add_b     = req_b[32*gnt_idx +: 32];
        add_sub   = req_sub[gnt_idx];
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    fp32_addsub u_addsub (
        .clk      (clk),
        .rst      (rst),
        .a        (add_a),
        .b        (add_b),
        .sub      (add_sub),
        .y        (add_y),
        .overflow (add_ovf),
        .y_q      (unused_stage_y)
    );

    // Pointer advance, one-cycle response capture and completed-operation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_y_q        <= FP32_POS_ZERO;
            rsp_overflow_q <= 1'b0;
            ops_cnt_q      <= 32'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_id_q       <= gnt_idx;
                rsp_y_q        <= add_y;
                rsp_overflow_q <= add_ovf;
                ops_cnt_q      <= ops_cnt_q + 32'd1;
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_overflow = rsp_overflow_q;
    assign ops_cnt      = ops_cnt_q;

endmodule : fp32_addsub_rr_arb

// File: tb/tb_fp32_addsub_rr_arb.sv
// tb/tb_fp32_addsub_rr_arb.sv - directed self-checking bench for fp32_addsub_rr_arb
module tb_fp32_addsub_rr_arb;

    logic         clk;
    logic         rst;
    logic         hold;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_sub;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_y;
    logic         rsp_overflow;
    logic [31:0]  ops_cnt;

    int total;
    int bad;

    fp32_addsub_rr_arb #(.NUM_REQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_y        (rsp_y),
        .rsp_overflow (rsp_overflow),
        .ops_cnt      (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_y", rsp_y, 32'h0);
        check("rst_ovf", 32'(rsp_overflow), 32'h0);
        check("rst_ops", ops_cnt, 32'h0);
        after_edge();
        rst       = 1'b0;
        req_valid = 4'h0;

        // Single request on lane 2: 1.0 + 2.0
        set_lane(2, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h4);
        after_edge();
        req_valid = 4'h0;
        check("t1_valid", 32'(rsp_valid), 32'h1);
        check("t1_id", 32'(rsp_id), 32'h2);
        check("t1_y", rsp_y, 32'h4040_0000);
        check("t1_ops", ops_cnt, 32'h1);

        // Lane 0 subtraction 1.0 - 3.0 (pointer now 3, wraps to lane 0)
        set_lane(0, 32'h3F80_0000, 32'h4040_0000, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t2_ready", 32'(req_ready), 32'h1);
        after_edge();
        req_valid = 4'h0;
        check("t2_y", rsp_y, 32'hC000_0000);
        check("t2_ovf", 32'(rsp_overflow), 32'h0);
        check("t2_id", 32'(rsp_id), 32'h0);

        // Exact zero on lane 1: 3.0 - 3.0
        set_lane(1, 32'h4040_0000, 32'h4040_0000, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        check("t3_ready", 32'(req_ready), 32'h2);
        after_edge();
        req_valid = 4'h0;
        check("t3_y", rsp_y, 32'h0000_0000);

        // Overflow on lane 2: max finite + max finite
        set_lane(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
        req_valid = 4'b0100;
        after_edge();
        req_valid = 4'h0;
        check("t4_y", rsp_y, 32'h7F80_0000);
        check("t4_ovf", 32'(rsp_overflow), 32'h1);
        check("t4_ops", ops_cnt, 32'h4);
        after_edge();
        check("t4_idle_valid", 32'(rsp_valid), 32'h0);
        check("t4_idle_y_hold", rsp_y, 32'h7F80_0000);

        // Fresh reset, then all four lanes continuously valid for 8 cycles
        rst = 1'b1;
        after_edge();
        rst = 1'b0;
        check("t5_ops_rst", ops_cnt, 32'h0);
        for (int i = 0; i < 4; i++) set_lane(i, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t5_ready%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            after_edge();
            check($sformatf("t5_id%0d", i), 32'(rsp_id), 32'(i % 4));
            check($sformatf("t5_y%0d", i), rsp_y, 32'h4000_0000);
        end
        req_valid = 4'h0;
        check("t5_ops", ops_cnt, 32'h8);

        // Hold with lanes 1 and 3 pending, after lane 0 was granted
        req_valid = 4'b0001;
        after_edge();
        hold      = 1'b1;
        req_valid = 4'b1010;
        check("t6_prev_valid", 32'(rsp_valid), 32'h1);
        check("t6_prev_id", 32'(rsp_id), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_hold_ready%0d", i), 32'(req_ready), 32'h0);
            after_edge();
            check($sformatf("t6_hold_rsp%0d", i), 32'(rsp_valid), 32'h0);
        end
        hold = 1'b0;
        @(negedge clk);
        check("t6_first", 32'(req_ready), 32'h2);
        after_edge();
        check("t6_first_id", 32'(rsp_id), 32'h1);
        @(negedge clk);
        check("t6_second", 32'(req_ready), 32'h8);
        after_edge();
        check("t6_second_id", 32'(rsp_id), 32'h3);
        req_valid = 4'h0;
        check("t6_ops", ops_cnt, 32'hB);

        // Async reset mid-cycle during an acceptance cycle
        req_valid = 4'b0100;
        @(negedge clk);
        check("t7_ready", 32'(req_ready), 32'h4);
        #1;
        rst = 1'b1;
        #1;
        check("t7_ready_rst", 32'(req_ready), 32'h0);
        check("t7_ops_rst", ops_cnt, 32'h0);
        after_edge();
        check("t7_no_rsp", 32'(rsp_valid), 32'h0);
        #3;
        rst       = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        check("t7_prio", 32'(req_ready), 32'h1);
        after_edge();
        req_valid = 4'h0;
        check("t7_rsp_id", 32'(rsp_id), 32'h0);
        check("t7_ops", ops_cnt, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp32_addsub_rr_arb
